dmem_arbiter: RTL and testbench

- Fixed-latency controller that shares the single-port data memory between two requesters: the CPU pipeline MEM stage and a DMA/loader port.
- Sits between the EX/MEM pipeline register and the data memory.
- Stalls the pipeline while a CPU access is pending or waiting.
- Grants the DMA port under a bounded-starvation policy.

---
 rtl/dmem_arbiter.sv | 146 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares the single-port data memory between the CPU MEM stage and a DMA/loader
// port. Every access takes exactly MEM_LAT busy cycles, which are counted
// internally. An IDLE acceptance cycle comes before each access. The CPU wins
// simultaneous requests unless the DMA port has already waited through
// STARVE_MAX consecutive CPU grants.
//
// Ports:
//   clk_i, rst_i          clock (rising edge), asynchronous active-high reset
//   cpu_req_i/we/addr/wdata  MEM-stage access request
//   cpu_stall_o           freeze the pipeline until the CPU access completes
//   cpu_rdata_o           load data, valid when cpu_req_i & ~cpu_stall_o
//   dma_req_i/we/addr/wdata  DMA request, held until dma_done_o
//   dma_gnt_o             DMA access in progress
//   dma_done_o            one-cycle DMA completion pulse
//   dma_rdata_o           registered DMA read data, held until next DMA read
//   mem_addr_o/wdata_o    memory address / write data (0 while idle)
//   mem_read_o            read strobe for every busy cycle of a read
//   mem_write_o           write strobe on the last busy cycle only
//   mem_rdata_i           memory read data, valid on the last busy cycle
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cpu_req_i,
    input  logic        cpu_we_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [31:0] cpu_wdata_i,
    output logic        cpu_stall_o,
    output logic [31:0] cpu_rdata_o,
    input  logic        dma_req_i,
    input  logic        dma_we_i,
    input  logic [31:0] dma_addr_i,
    input  logic [31:0] dma_wdata_i,
    output logic        dma_gnt_o,
    output logic        dma_done_o,
    output logic [31:0] dma_rdata_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic        mem_read_o,
    output logic        mem_write_o,
    input  logic [31:0] mem_rdata_i
);
    localparam int CNT_W = $clog2(MEM_LAT + 1);
    localparam int STV_W = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CPU_BUSY = 2'd1,
        ST_DMA_BUSY = 2'd2
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [STV_W-1:0]   r_starve;
    logic [31:0]        r_addr;
    logic [31:0]        r_wdata;
    logic               r_we;
    logic [31:0]        r_dma_rdata;

    logic               w_busy;
    logic               w_last;
    logic               w_cpu_done;
    logic               w_dma_done;
    logic               w_starved;
    logic               w_cpu_win;

    assign w_busy     = (r_state == ST_CPU_BUSY) || (r_state == ST_DMA_BUSY);
    assign w_last     = w_busy && (r_cnt == CNT_W'(MEM_LAT - 1));
    assign w_cpu_done = (r_state == ST_CPU_BUSY) && w_last;
    assign w_dma_done = (r_state == ST_DMA_BUSY) && w_last;
    // DMA has waited through STARVE_MAX CPU grants: it takes the next slot.
    assign w_starved  = dma_req_i && (r_starve == STV_W'(STARVE_MAX));
    assign w_cpu_win  = cpu_req_i && !w_starved;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_starve    <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_we        <= 1'b0;
            r_dma_rdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (w_cpu_win) begin
                        r_state  <= ST_CPU_BUSY;
                        r_addr   <= cpu_addr_i;
                        r_wdata  <= cpu_wdata_i;
                        r_we     <= cpu_we_i;
                        // Only grants taken while DMA is waiting count
                        // toward starvation.
                        r_starve <= dma_req_i ? (r_starve + 1'b1) : '0;
                    end else if (dma_req_i) begin
                        r_state  <= ST_DMA_BUSY;
                        r_addr   <= dma_addr_i;
                        r_wdata  <= dma_wdata_i;
                        r_we     <= dma_we_i;
                        r_starve <= '0;
                    end else begin
                        r_starve <= '0;
                    end
                end
                ST_CPU_BUSY, ST_DMA_BUSY: begin
                    if (w_last) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                        if (w_dma_done && !r_we) begin
                            r_dma_rdata <= mem_rdata_i;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Memory side is driven only while an access is in flight; a write
    // strobes once on the final cycle so that each store commits exactly once.
    assign mem_addr_o  = w_busy ? r_addr  : 32'h0;
    assign mem_wdata_o = w_busy ? r_wdata : 32'h0;
    assign mem_read_o  = w_busy && !r_we;
    assign mem_write_o = w_last && r_we;

    // The stall drops in the completion cycle so that the pipeline advances
    // on the same edge that the FSM returns to IDLE.
    assign cpu_stall_o = cpu_req_i && !w_cpu_done;
    assign cpu_rdata_o = (w_cpu_done && !r_we) ? mem_rdata_i : 32'h0;

    assign dma_gnt_o   = (r_state == ST_DMA_BUSY);
    assign dma_done_o  = w_dma_done;
    assign dma_rdata_o = r_dma_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // DUT A: MEM_LAT=2, STARVE_MAX=4
    logic        cpu_req, cpu_we, cpu_stall;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        dma_req, dma_we, dma_gnt, dma_done;
    logic [31:0] dma_addr, dma_wdata, dma_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_read, mem_write;

    // DUT B: MEM_LAT=1, CPU traffic only
    logic        b_cpu_req, b_cpu_we, b_cpu_stall;
    logic [31:0] b_cpu_addr, b_cpu_wdata, b_cpu_rdata;
    logic        b_dma_req, b_dma_we, b_dma_gnt, b_dma_done;
    logic [31:0] b_dma_addr, b_dma_wdata, b_dma_rdata;
    logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic        b_mem_read, b_mem_write;

    dmem_arbiter #(.MEM_LAT(2), .STARVE_MAX(4)) u_dut (
        .clk_i(clk), .rst_i(rst),
        .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr),
        .cpu_wdata_i(cpu_wdata), .cpu_stall_o(cpu_stall), .cpu_rdata_o(cpu_rdata),
        .dma_req_i(dma_req), .dma_we_i(dma_we), .dma_addr_i(dma_addr),
        .dma_wdata_i(dma_wdata), .dma_gnt_o(dma_gnt), .dma_done_o(dma_done),
        .dma_rdata_o(dma_rdata), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_read_o(mem_read), .mem_write_o(mem_write), .mem_rdata_i(mem_rdata)
    );

    dmem_arbiter #(.MEM_LAT(1), .STARVE_MAX(4)) u_dut_b (
        .clk_i(clk), .rst_i(rst),
        .cpu_req_i(b_cpu_req), .cpu_we_i(b_cpu_we), .cpu_addr_i(b_cpu_addr),
        .cpu_wdata_i(b_cpu_wdata), .cpu_stall_o(b_cpu_stall), .cpu_rdata_o(b_cpu_rdata),
        .dma_req_i(b_dma_req), .dma_we_i(b_dma_we), .dma_addr_i(b_dma_addr),
        .dma_wdata_i(b_dma_wdata), .dma_gnt_o(b_dma_gnt), .dma_done_o(b_dma_done),
        .dma_rdata_o(b_dma_rdata), .mem_addr_o(b_mem_addr), .mem_wdata_o(b_mem_wdata),
        .mem_read_o(b_mem_read), .mem_write_o(b_mem_write), .mem_rdata_i(b_mem_rdata)
    );

    // ---------------- memory model and reference image ----------------
    function automatic logic [31:0] seed(input int i);
        if (i == 4)       return 32'hDEADBEEF;
        else if (i == 16) return 32'hCAFEF00D;
        else              return 32'h1000_0000 + 32'(i) * 32'h0001_0101;
    endfunction

    logic [31:0] mem_a [0:255];
    logic [31:0] exp_a [0:255];
    bit          mem_ready = 1'b0;

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) mem_a[i] = seed(i);
            mem_ready = 1'b1;
        end else if (mem_write) begin
            mem_a[mem_addr[9:2]] = mem_wdata;
        end
    end

    assign mem_rdata   = mem_read   ? mem_a[mem_addr[9:2]]   : 32'h0;
    assign b_mem_rdata = b_mem_read ? mem_a[b_mem_addr[9:2]] : 32'h0;

    // ---------------- checking ----------------
    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, exp);
        end
    endtask

    // ---------------- scoreboards ----------------
    logic [31:0] cpu_q [$];
    logic [31:0] dma_q [$];
    logic [31:0] b_q   [$];
    bit          dma_pend = 1'b0;
    logic [31:0] gnt_log  = 32'h0;   // shift register: 0 = CPU grant, 1 = DMA grant
    int          gnt_n    = 0;

    always @(negedge clk) begin
        if (dma_pend) begin
            dma_pend = 1'b0;
            if (dma_q.size() == 0) chk("dma_q_empty", 32'(dma_q.size()), 32'd1);
            else begin
                $display("dma read rdata=%h", dma_rdata);
                chk("dma_rdata", dma_rdata, dma_q.pop_front());
            end
        end
        if (cpu_req && !cpu_stall) begin
            gnt_log = {gnt_log[30:0], 1'b0};
            gnt_n++;
            $display("cpu done we=%0b addr=%h rdata=%h", cpu_we, cpu_addr, cpu_rdata);
            if (cpu_q.size() == 0) chk("cpu_q_empty", 32'(cpu_q.size()), 32'd1);
            else chk("cpu_rdata", cpu_rdata, cpu_q.pop_front());
        end
        if (dma_done) begin
            gnt_log = {gnt_log[30:0], 1'b1};
            gnt_n++;
            $display("dma done we=%0b addr=%h", dma_we, dma_addr);
            if (!dma_we) dma_pend = 1'b1;
        end
        if (b_cpu_req && !b_cpu_stall) begin
            $display("b cpu done addr=%h rdata=%h", b_cpu_addr, b_cpu_rdata);
            if (b_q.size() == 0) chk("b_q_empty", 32'(b_q.size()), 32'd1);
            else chk("t6_rdata", b_cpu_rdata, b_q.pop_front());
        end
    end

    // ---------------- transaction tasks ----------------
    task automatic cpu_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input string tag);
        bit done = 1'b0;
        cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1'b1;
        if (we) begin
            exp_a[addr[9:2]] = wdata;
            cpu_q.push_back(32'h0);
        end else begin
            cpu_q.push_back(exp_a[addr[9:2]]);
        end
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (!cpu_stall) done = 1'b1;
            @(posedge clk); #1;
        end
        chk({tag, "_timeout"}, 32'(done), 32'd1);
        cpu_req = 1'b0;
    endtask

    task automatic dma_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input string tag);
        bit done = 1'b0;
        dma_we = we; dma_addr = addr; dma_wdata = wdata; dma_req = 1'b1;
        if (we) exp_a[addr[9:2]] = wdata;
        else    dma_q.push_back(exp_a[addr[9:2]]);
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (dma_done) done = 1'b1;
            @(posedge clk); #1;
        end
        chk({tag, "_timeout"}, 32'(done), 32'd1);
        dma_req = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    int   ncpu;
    logic dd;

    initial begin
        for (int i = 0; i < 256; i++) exp_a[i] = seed(i);
        rst = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
        b_cpu_req = 0; b_cpu_we = 0; b_cpu_addr = 0; b_cpu_wdata = 0;
        b_dma_req = 0; b_dma_we = 0; b_dma_addr = 0; b_dma_wdata = 0;

        // Reset state
        @(negedge clk); @(negedge clk);
        chk("rst_stall",   32'(cpu_stall), 32'd0);
        chk("rst_mem_rd",  32'(mem_read),  32'd0);
        chk("rst_mem_wr",  32'(mem_write), 32'd0);
        chk("rst_addr",    mem_addr,       32'h0);
        chk("rst_gnt",     32'(dma_gnt),   32'd0);
        chk("rst_done",    32'(dma_done),  32'd0);
        chk("rst_drdata",  dma_rdata,      32'h0);
        cpu_req = 1'b1;
        #1 chk("rst_stall_req", 32'(cpu_stall), 32'd1);
        cpu_req = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;

        // Test 1: CPU load 0x10
        cpu_we = 0; cpu_addr = 32'h10; cpu_req = 1'b1;
        cpu_q.push_back(32'hDEADBEEF);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("t1_stall", 32'(cpu_stall), 32'(c < 2));
            chk("t1_rd",    32'(mem_read),  32'(c >= 1));
            chk("t1_wr",    32'(mem_write), 32'd0);
            @(posedge clk); #1;
        end
        cpu_req = 1'b0;
        @(posedge clk); #1;

        // Test 2: CPU store 0x20 <= 0x1234
        cpu_we = 1; cpu_addr = 32'h20; cpu_wdata = 32'h0000_1234; cpu_req = 1'b1;
        exp_a[8] = 32'h0000_1234;
        cpu_q.push_back(32'h0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("t2_stall", 32'(cpu_stall), 32'(c < 2));
            chk("t2_wr",    32'(mem_write), 32'(c == 2));
            chk("t2_rd",    32'(mem_read),  32'd0);
            if (c == 2) begin
                chk("t2_addr",  mem_addr,  32'h20);
                chk("t2_wdata", mem_wdata, 32'h1234);
            end
            @(posedge clk); #1;
        end
        cpu_req = 1'b0; cpu_we = 0;
        @(posedge clk); #1;

        // Test 3: DMA read 0x40
        dma_we = 0; dma_addr = 32'h40; dma_req = 1'b1;
        dma_q.push_back(32'hCAFEF00D);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("t3_gnt",  32'(dma_gnt),  32'(c >= 1));
            chk("t3_done", 32'(dma_done), 32'(c == 2));
            @(posedge clk); #1;
        end
        dma_req = 1'b0;
        @(posedge clk); #1; @(posedge clk); #1;
        @(negedge clk);
        chk("t3_hold", dma_rdata, 32'hCAFEF00D);
        @(posedge clk); #1;

        // DMA write must leave dma_rdata_o alone; CPU then reads it back
        dma_op(1'b1, 32'h60, 32'h0000_0077, "dma_wr");
        @(negedge clk);
        chk("dwr_hold", dma_rdata, 32'hCAFEF00D);
        @(posedge clk); #1;
        cpu_op(1'b0, 32'h60, 32'h0, "ld60");
        cpu_op(1'b0, 32'h20, 32'h0, "ld20");

        // Test 4: starvation bound with both requests held
        @(posedge clk); #1;
        gnt_log = 32'h0; gnt_n = 0; ncpu = 0;
        for (int k = 0; k < 5; k++) cpu_q.push_back(exp_a[12]);
        dma_q.push_back(exp_a[17]);
        cpu_we = 0; cpu_addr = 32'h30; cpu_req = 1'b1;
        dma_we = 0; dma_addr = 32'h44; dma_req = 1'b1;
        for (int c = 0; c < 40 && ncpu < 5; c++) begin
            @(negedge clk);
            if (cpu_req && !cpu_stall) ncpu++;
            dd = dma_done;
            @(posedge clk); #1;
            if (dd) dma_req = 1'b0;
            if (ncpu == 5) cpu_req = 1'b0;
        end
        cpu_req = 1'b0; dma_req = 1'b0;
        chk("t4_timeout", 32'(ncpu), 32'd5);
        @(posedge clk); #1;
        chk("t4_count", 32'(gnt_n), 32'd6);
        chk("t4_order", gnt_log, 32'h2);

        // Test 5: reset during CPU_BUSY cnt=0 of a store
        cpu_we = 1; cpu_addr = 32'h50; cpu_wdata = 32'h5555; cpu_req = 1'b1;
        @(posedge clk); #2;
        rst = 1'b1;
        @(negedge clk);
        chk("t5_wr",    32'(mem_write), 32'd0);
        chk("t5_rd",    32'(mem_read),  32'd0);
        chk("t5_addr",  mem_addr,       32'h0);
        chk("t5_wdata", mem_wdata,      32'h0);
        chk("t5_gnt",   32'(dma_gnt),   32'd0);
        chk("t5_done",  32'(dma_done),  32'd0);
        chk("t5_drd",   dma_rdata,      32'h0);
        chk("t5_stall", 32'(cpu_stall), 32'd1);
        cpu_req = 1'b0; cpu_we = 0;
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("t5_mem", mem_a[20], exp_a[20]);
        @(posedge clk); #1;
        cpu_op(1'b0, 32'h50, 32'h0, "ld50");

        // Test 6: MEM_LAT=1, three back-to-back loads on DUT B
        b_cpu_we = 0; b_cpu_addr = 32'h10; b_cpu_req = 1'b1;
        b_q.push_back(exp_a[4]);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("t6_stall", 32'(b_cpu_stall), 32'(c % 2 == 0));
            @(posedge clk); #1;
            if (c == 1) begin b_cpu_addr = 32'h40; b_q.push_back(exp_a[16]); end
            if (c == 3) begin b_cpu_addr = 32'h20; b_q.push_back(exp_a[8]);  end
            if (c == 5) b_cpu_req = 1'b0;
        end
        @(posedge clk); #1;

        chk("cpu_q_left", 32'(cpu_q.size()), 32'd0);
        chk("dma_q_left", 32'(dma_q.size()), 32'd0);
        chk("b_q_left",   32'(b_q.size()),   32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule
